// File: rtl/hd44780_fifo_controller.sv
// hd44780_fifo_controller: FIFO-buffered HD44780 LCD driver with optional
// power-on init, 4- or 8-bit bus, and clock-count bus timing.
// Ports: CLK_I, RST_I (async, active-low); host push STB_I, i_rs, i_lcd_data;
// status busy/full/empty/ovf, alive_led; LCD pins o_rs, o_e, o_lcd_data.
module hd44780_fifo_controller #(
   parameter int DATA_MODE           = 4,
   parameter int FIFO_AW             = 4,
   parameter int SETUP_CYCLES        = 2,
   parameter int E_PULSE_CYCLES      = 12,
   parameter int HOLD_CYCLES         = 2,
   parameter int CMD_WAIT_CYCLES     = 2000,
   parameter int CLEAR_WAIT_CYCLES   = 80000,
   parameter int POWERON_WAIT_CYCLES = 800000,
   parameter int INIT_WAIT_CYCLES    = 240000,
   parameter int INIT_ENABLE         = 1,
   parameter int ALIVE_BITS          = 22
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       STB_I,
   input  logic       i_rs,
   input  logic [7:0] i_lcd_data,
   output logic       busy,
   output logic       full,
   output logic       empty,
   output logic       ovf,
   output logic       alive_led,
   output logic       o_rs,
   output logic       o_e,
   output logic [7:0] o_lcd_data
);

   if (DATA_MODE != 4 && DATA_MODE != 8) begin : g_bad_mode
      $error("hd44780_fifo_controller: DATA_MODE must be 4 or 8");
   end

   typedef enum logic [2:0] {
      S_POWERON, S_INIT, S_IDLE, S_LOAD,
      S_SETUP, S_EHIGH, S_HOLD, S_WAIT
   } state_t;

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [3:0] C_STEPS = (DATA_MODE == 4) ? 4'd8 : 4'd7;
   localparam logic [3:0] C_RST_STEP = (INIT_ENABLE != 0) ? 4'd0 : C_STEPS;
   localparam state_t C_RST_STATE = (INIT_ENABLE != 0) ? S_POWERON : S_IDLE;

   // FIFO
   logic [8:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic [FIFO_AW:0]   w_count_nxt;
   logic               r_full;
   logic               r_empty;
   logic               r_ovf;
   logic               w_push;
   logic               w_pop;
   logic [8:0]         w_rd;

   // FSM and datapath
   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cnt;
   logic [31:0] w_dur;
   logic        w_done;
   logic        r_rs;
   logic [7:0]  r_byte;
   logic        r_hi;
   logic        r_single;
   logic [31:0] r_wait_len;
   logic [3:0]  r_step;
   logic [7:0]  w_init_byte;
   logic        w_init_single;
   logic        w_init_wake;
   logic        w_split;
   logic [ALIVE_BITS-1:0] r_alive;

   assign w_push = STB_I & ~r_full;
   assign w_rd   = r_mem[r_rptr];

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (FIFO_AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (FIFO_AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (w_push) r_mem[r_wptr] <= {i_rs, i_lcd_data};
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (FIFO_AW+1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         if (STB_I && r_full) r_ovf <= 1'b1;
      end
   end

   // Clear (0x01) and home (0x02/0x03) need the long settle time.
   function automatic logic [31:0] f_wait(input logic rs, input logic [7:0] b);
      if (!rs && b != 8'h00 && b <= 8'h03) return 32'(CLEAR_WAIT_CYCLES);
      return 32'(CMD_WAIT_CYCLES);
   endfunction

   // Init table: three wake-ups, (4-bit) a bus-width switch nybble,
   // then the function-set / display / clear / entry-mode bytes.
   always_comb begin
      w_init_byte   = 8'h06;
      w_init_single = 1'b0;
      w_init_wake   = 1'b0;
      if (r_step < 4'd3) begin
         w_init_byte   = 8'h30;
         w_init_single = 1'b1;
         w_init_wake   = 1'b1;
      end else if (DATA_MODE == 4) begin
         unique case (r_step)
            4'd3: begin
               w_init_byte   = 8'h20;
               w_init_single = 1'b1;
            end
            4'd4:    w_init_byte = 8'h28;
            4'd5:    w_init_byte = 8'h0C;
            4'd6:    w_init_byte = 8'h01;
            default: w_init_byte = 8'h06;
         endcase
      end else begin
         unique case (r_step)
            4'd3:    w_init_byte = 8'h38;
            4'd4:    w_init_byte = 8'h0C;
            4'd5:    w_init_byte = 8'h01;
            default: w_init_byte = 8'h06;
         endcase
      end
   end

   always_comb begin
      w_dur = 32'd1;
      unique case (r_state)
         S_POWERON: w_dur = 32'(POWERON_WAIT_CYCLES);
         S_SETUP:   w_dur = 32'(SETUP_CYCLES);
         S_EHIGH:   w_dur = 32'(E_PULSE_CYCLES);
         S_HOLD:    w_dur = 32'(HOLD_CYCLES);
         S_WAIT:    w_dur = r_wait_len;
         default:   w_dur = 32'd1;
      endcase
   end

   assign w_done  = (r_cnt == w_dur - 32'd1);
   assign w_split = (DATA_MODE == 4) && r_hi && !r_single;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) r_state <= C_RST_STATE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      unique case (r_state)
         S_POWERON: if (w_done) w_next = S_INIT;
         S_INIT:    w_next = S_SETUP;
         S_IDLE:    if (!r_empty) w_next = S_LOAD;
         S_LOAD: begin
            w_pop  = 1'b1;
            w_next = S_SETUP;
         end
         S_SETUP:   if (w_done) w_next = S_EHIGH;
         S_EHIGH:   if (w_done) w_next = S_HOLD;
         S_HOLD:    if (w_done) w_next = w_split ? S_SETUP : S_WAIT;
         S_WAIT: begin
            // Init steps outrank queued host entries; host entries
            // then follow without an IDLE bubble.
            if (w_done) begin
               if (r_step < C_STEPS) w_next = S_INIT;
               else if (!r_empty)    w_next = S_LOAD;
               else                  w_next = S_IDLE;
            end
         end
         default:   w_next = S_IDLE;
      endcase
   end

   // Per-state cycle counter, restarted on every state change.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I)                r_cnt <= '0;
      else if (w_next != r_state) r_cnt <= '0;
      else                       r_cnt <= r_cnt + 32'd1;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_rs       <= 1'b0;
         r_byte     <= 8'h00;
         r_hi       <= 1'b0;
         r_single   <= 1'b0;
         r_wait_len <= 32'(CMD_WAIT_CYCLES);
         r_step     <= C_RST_STEP;
      end else begin
         unique case (1'b1)
            (r_state == S_LOAD): begin
               r_rs       <= w_rd[8];
               r_byte     <= w_rd[7:0];
               r_hi       <= 1'b1;
               r_single   <= 1'b0;
               r_wait_len <= f_wait(w_rd[8], w_rd[7:0]);
            end
            (r_state == S_INIT): begin
               r_rs       <= 1'b0;
               r_byte     <= w_init_byte;
               r_hi       <= 1'b1;
               r_single   <= w_init_single;
               r_wait_len <= w_init_wake ? 32'(INIT_WAIT_CYCLES)
                                         : f_wait(1'b0, w_init_byte);
               r_step     <= r_step + 4'd1;
            end
            (r_state == S_HOLD && w_next == S_SETUP): r_hi <= 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) r_alive <= '0;
      else        r_alive <= r_alive + ALIVE_BITS'(1);
   end

   // o_e decodes the state register so reset drops it without a clock.
   assign o_e        = (r_state == S_EHIGH);
   assign o_rs       = r_rs;
   assign o_lcd_data = (DATA_MODE == 4)
                     ? {(r_hi ? r_byte[7:4] : r_byte[3:0]), 4'h0}
                     : r_byte;
   assign busy       = (r_state != S_IDLE) || !r_empty;
   assign full       = r_full;
   assign empty      = r_empty;
   assign ovf        = r_ovf;
   assign alive_led  = r_alive[ALIVE_BITS-1];

endmodule

// File: tb/tb_hd44780_fifo_controller.sv
// tb_hd44780_fifo_controller: scoreboard bench for three controller builds
// (4-bit no-init FIFO_AW=2, 8-bit no-init, 4-bit with init).
module tb_hd44780_fifo_controller;

   localparam int SU  = 2;
   localparam int EP  = 4;
   localparam int HO  = 2;
   localparam int CW  = 10;
   localparam int CLW = 50;
   localparam int PW  = 100;
   localparam int IW  = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;

   logic       rst_n [3];
   logic       stb   [3];
   logic       rs_i  [3];
   logic [7:0] d_i   [3];
   logic       busy  [3];
   logic       full  [3];
   logic       empty [3];
   logic       ovf   [3];
   logic       alive [3];
   logic       o_rs  [3];
   logic       o_e   [3];
   logic [7:0] o_d   [3];

   hd44780_fifo_controller #(
      .DATA_MODE(4), .FIFO_AW(2), .SETUP_CYCLES(SU),
      .E_PULSE_CYCLES(EP), .HOLD_CYCLES(HO), .CMD_WAIT_CYCLES(CW),
      .CLEAR_WAIT_CYCLES(CLW), .POWERON_WAIT_CYCLES(PW),
      .INIT_WAIT_CYCLES(IW), .INIT_ENABLE(0), .ALIVE_BITS(22)
   ) u_a (
      .CLK_I(clk), .RST_I(rst_n[0]), .STB_I(stb[0]), .i_rs(rs_i[0]),
      .i_lcd_data(d_i[0]), .busy(busy[0]), .full(full[0]),
      .empty(empty[0]), .ovf(ovf[0]), .alive_led(alive[0]),
      .o_rs(o_rs[0]), .o_e(o_e[0]), .o_lcd_data(o_d[0])
   );

   hd44780_fifo_controller #(
      .DATA_MODE(8), .FIFO_AW(4), .SETUP_CYCLES(SU),
      .E_PULSE_CYCLES(EP), .HOLD_CYCLES(HO), .CMD_WAIT_CYCLES(CW),
      .CLEAR_WAIT_CYCLES(CLW), .POWERON_WAIT_CYCLES(PW),
      .INIT_WAIT_CYCLES(IW), .INIT_ENABLE(0), .ALIVE_BITS(22)
   ) u_b (
      .CLK_I(clk), .RST_I(rst_n[1]), .STB_I(stb[1]), .i_rs(rs_i[1]),
      .i_lcd_data(d_i[1]), .busy(busy[1]), .full(full[1]),
      .empty(empty[1]), .ovf(ovf[1]), .alive_led(alive[1]),
      .o_rs(o_rs[1]), .o_e(o_e[1]), .o_lcd_data(o_d[1])
   );

   hd44780_fifo_controller #(
      .DATA_MODE(4), .FIFO_AW(4), .SETUP_CYCLES(SU),
      .E_PULSE_CYCLES(EP), .HOLD_CYCLES(HO), .CMD_WAIT_CYCLES(CW),
      .CLEAR_WAIT_CYCLES(CLW), .POWERON_WAIT_CYCLES(PW),
      .INIT_WAIT_CYCLES(IW), .INIT_ENABLE(1), .ALIVE_BITS(22)
   ) u_d (
      .CLK_I(clk), .RST_I(rst_n[2]), .STB_I(stb[2]), .i_rs(rs_i[2]),
      .i_lcd_data(d_i[2]), .busy(busy[2]), .full(full[2]),
      .empty(empty[2]), .ovf(ovf[2]), .alive_led(alive[2]),
      .o_rs(o_rs[2]), .o_e(o_e[2]), .o_lcd_data(o_d[2])
   );

   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [8:0] q2 [$];

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                    nm, act, act, exp, exp);
   endtask

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [8:0] qpop(input int i);
      case (i)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic qpush(input int i, input logic [8:0] v);
      case (i)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic exp4(input int i, input logic rs, input logic [7:0] b);
      qpush(i, {rs, b[7:4], 4'h0});
      qpush(i, {rs, b[3:0], 4'h0});
   endtask

   task automatic exp_init4();
      qpush(2, 9'h030);
      qpush(2, 9'h030);
      qpush(2, 9'h030);
      qpush(2, 9'h020);
      exp4(2, 1'b0, 8'h28);
      exp4(2, 1'b0, 8'h0C);
      exp4(2, 1'b0, 8'h01);
      exp4(2, 1'b0, 8'h06);
   endtask

   // Monitor: compare bus contents at each E rising edge and E width.
   int   n_pulse [3];
   int   t_rise  [3];
   int   t_fall  [3];
   int   t_first [3];
   int   wcnt    [3];
   logic e_prev  [3];

   task automatic pop_cmp(input int i);
      logic [8:0] got;
      logic [8:0] exp;
      got = {o_rs[i], o_d[i]};
      if (qsize(i) == 0) begin
         n_tot++;
         $display("FAIL bus%0d_unexpected: got rs/data 0x%0h, none queued",
                  i, got);
      end else begin
         exp = qpop(i);
         chk($sformatf("bus%0d_pulse%0d", i, n_pulse[i]), int'(got), int'(exp));
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (o_e[i] && !e_prev[i] && rst_n[i]) begin
            n_pulse[i]++;
            t_rise[i] = cyc;
            if (n_pulse[i] == 1) t_first[i] = cyc;
            wcnt[i] = 0;
            pop_cmp(i);
         end
         if (o_e[i]) wcnt[i]++;
         if (!o_e[i] && e_prev[i]) begin
            t_fall[i] = cyc;
            if (rst_n[i]) chk($sformatf("e_width%0d", i), wcnt[i], EP);
         end
         e_prev[i] = o_e[i];
      end
   end

   int t_push;

   task automatic push(input int i, input logic rs, input logic [7:0] b);
      @(negedge clk);
      stb[i]  = 1'b1;
      rs_i[i] = rs;
      d_i[i]  = b;
      @(negedge clk);
      stb[i]  = 1'b0;
      t_push  = cyc;
   endtask

   task automatic wait_idle(input int i, input int budget, input string nm);
      for (int k = 0; k < budget && busy[i]; k++) @(negedge clk);
      chk(nm, busy[i], 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t_rel;
      int base;
      for (int i = 0; i < 3; i++) begin
         rst_n[i]   = 1'b0;
         stb[i]     = 1'b0;
         rs_i[i]    = 1'b0;
         d_i[i]     = 8'h00;
         n_pulse[i] = 0;
         t_rise[i]  = 0;
         t_fall[i]  = 0;
         t_first[i] = 0;
         wcnt[i]    = 0;
         e_prev[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);

      chk("a_rst_busy",  busy[0],  0);
      chk("a_rst_empty", empty[0], 1);
      chk("a_rst_full",  full[0],  0);
      chk("a_rst_ovf",   ovf[0],   0);
      chk("a_rst_e",     o_e[0],   0);
      chk("a_rst_rs",    o_rs[0],  0);
      chk("a_rst_data",  o_d[0],   0);
      chk("a_rst_alive", alive[0], 0);
      chk("b_rst_busy",  busy[1],  0);
      chk("d_rst_busy",  busy[2],  1);
      chk("d_rst_empty", empty[2], 1);

      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      t_rel = cyc;
      exp_init4();
      exp4(2, 1'b1, 8'h48);
      repeat (4) @(negedge clk);
      chk("d_busy_poweron", busy[2], 1);
      push(2, 1'b1, 8'h48);

      // 4-bit single write: latency, both nybbles, busy release.
      exp4(0, 1'b1, 8'h6D);
      push(0, 1'b1, 8'h6D);
      t0 = t_push;
      wait_idle(0, 200, "a_6d_idle");
      chk("a_latency", t_first[0] - t0, SU + 2);
      chk("a_busy_fall", cyc - t_fall[0], HO + CW);
      chk("a_6d_pulses", n_pulse[0], 2);

      // 8-bit clear: single pulse and the long wait.
      qpush(1, 9'h001);
      push(1, 1'b0, 8'h01);
      t0 = t_push;
      wait_idle(1, 300, "b_clr_idle");
      chk("b_latency", t_first[1] - t0, SU + 2);
      chk("b_busy_fall", cyc - t_fall[1], HO + CLW);
      chk("b_pulses", n_pulse[1], 1);

      // Push lands in the same cycle as the LOAD pop.
      exp4(0, 1'b0, 8'h35);
      exp4(0, 1'b1, 8'hA7);
      push(0, 1'b0, 8'h35);
      push(0, 1'b1, 8'hA7);
      chk("a_pushpop_empty", empty[0], 0);
      chk("a_pushpop_full",  full[0],  0);
      wait_idle(0, 300, "a_pushpop_idle");
      chk("a_ovf_before_burst", ovf[0], 0);

      // Burst of six into a depth-4 FIFO: 0x41..0x45 kept, 0x46 dropped.
      for (int k = 0; k < 5; k++) exp4(0, 1'b1, 8'h41 + 8'(k));
      base = n_pulse[0];
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         stb[0]  = 1'b1;
         rs_i[0] = 1'b1;
         d_i[0]  = 8'h41 + 8'(k);
         @(negedge clk);
      end
      stb[0] = 1'b0;
      chk("a_burst_full",  full[0],  1);
      chk("a_burst_ovf",   ovf[0],   1);
      chk("a_burst_empty", empty[0], 0);
      wait_idle(0, 1000, "a_burst_idle");
      chk("a_burst_pulses", n_pulse[0] - base, 10);
      chk("a_q_left", qsize(0), 0);
      chk("a_ovf_sticky", ovf[0], 1);

      // Init sequence, then the byte queued during power-on.
      wait_idle(2, 2000, "d_init_idle");
      chk("d_first_e", t_first[2] - t_rel, PW + 3);
      chk("d_init_pulses", n_pulse[2], 14);
      chk("d_q_left", qsize(2), 0);

      // Reset while E is high with one entry still queued.
      exp4(2, 1'b1, 8'h80);
      push(2, 1'b1, 8'h80);
      push(2, 1'b1, 8'hC0);
      for (int k = 0; k < 50 && !o_e[2]; k++) @(negedge clk);
      chk("d_mid_e_high", o_e[2], 1);
      chk("d_mid_not_empty", empty[2], 0);
      #1 rst_n[2] = 1'b0;
      #1;
      chk("d_rst_e",     o_e[2],   0);
      chk("d_rst_rs",    o_rs[2],  0);
      chk("d_rst_data",  o_d[2],   0);
      chk("d_rst_empty2", empty[2], 1);
      chk("d_rst_busy2", busy[2],  1);
      q2.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      t_rel = cyc;
      base = n_pulse[2];
      exp_init4();
      for (int k = 0; k < 300 && n_pulse[2] == base; k++) @(negedge clk);
      chk("d_restart_pulse", n_pulse[2] - base, 1);
      chk("d_restart_e", t_rise[2] - t_rel, PW + 3);
      wait_idle(2, 2000, "d_reinit_idle");
      chk("d_reinit_pulses", n_pulse[2] - base, 12);
      chk("d_q_left2", qsize(2), 0);
      chk("b_q_left", qsize(1), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
